// File: rtl/arb_defs.sv
// Shared constants and state encoding for the 4-way round-robin arbiter.
package arb_defs;
  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;
endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: first set request after ptr, wrapping around.
module rr_pick4
  import arb_defs::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   win_idx,
  output logic               any
);
  logic [IDX_W-1:0] idx;

  // Scan from farthest to nearest so the nearest set bit after ptr wins.
  always_comb begin
    win_idx = ptr;
    idx     = ptr;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = ptr + IDX_W'(k);
      if (req[idx]) win_idx = idx;
    end
    any = |req;
  end
endmodule

// File: rtl/rr_arb4_sel.sv
// Round-robin arbiter driving a 2-to-4 decoder: registered index/enable,
// hold timeout, and a one-cycle dead gap between consecutive grants.
module rr_arb4_sel
  import arb_defs::*;
#(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_en,
  output logic               timeout,
  output logic               busy
);
  localparam int CNT_W = (HOLD_MAX == 0) ? 1 : $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic             gnt_en_q, gnt_en_d;
  logic             timeout_q, timeout_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  logic [IDX_W-1:0] win_idx;
  logic             req_any;
  logic             release_now;
  logic             hold_hit;

  rr_pick4 u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .win_idx (win_idx),
    .any     (req_any)
  );

  always_comb begin
    state_d     = state_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_en_d    = 1'b0;
    timeout_d   = 1'b0;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    release_now = done || !req[gnt_idx_q];
    hold_hit    = (HOLD_MAX != 0) && (cnt_q == CNT_LIM);

    case (state_q)
      ST_IDLE, ST_GAP: begin
        if (req_any) begin
          state_d   = ST_GRANT;
          gnt_idx_d = win_idx;
          gnt_en_d  = 1'b1;
          cnt_d     = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        // A voluntary release takes precedence: timeout only flags a forced exit.
        if (release_now || hold_hit) begin
          state_d   = ST_GAP;
          ptr_d     = gnt_idx_q;
          timeout_d = !release_now;
        end else begin
          gnt_en_d = 1'b1;
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      gnt_idx_q <= '0;
      gnt_en_q  <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      ptr_q     <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_q   <= state_d;
      gnt_idx_q <= gnt_idx_d;
      gnt_en_q  <= gnt_en_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
    end
  end

  assign gnt_idx = gnt_idx_q;
  assign gnt_en  = gnt_en_q;
  assign timeout = timeout_q;
  assign busy    = busy_q;
endmodule
